instr_encoder: RTL



---
 rtl/instr_encoder_pkg.sv | 47 ++++
 rtl/instr_encoder_if.sv | 19 +
 rtl/instr_encoder_encode.sv | 35 +++
 rtl/instr_encoder.sv | 114 +++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg
// Shared constants for the instruction-memory loader: MIPS opcode and funct
// encodings (the same values the main control decoder decodes), request kind
// codes, loader FSM state encodings and two small word-building helpers.
package instr_encoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    KIND_ADD = 3'd0,
    KIND_SUB = 3'd1,
    KIND_AND = 3'd2,
    KIND_OR  = 3'd3,
    KIND_SLT = 3'd4,
    KIND_LW  = 3'd5,
    KIND_SW  = 3'd6,
    KIND_BEQ = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // R-format: shamt is always zero for the supported ALU operations
  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if
// Request channel of the loader: one symbolic instruction per valid/ready
// handshake.
//   master : producer of requests (drives valid and fields, sees ready)
//   slave  : the loader (sees valid and fields, drives ready)
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [15:0] req_imm;

  modport master (output req_valid, req_kind, req_rs, req_rt, req_rd, req_imm,
                  input  req_ready);
  modport slave  (input  req_valid, req_kind, req_rs, req_rt, req_rd, req_imm,
                  output req_ready);
endinterface

// File: rtl/instr_encoder_encode.sv
// instr_encode_comb
// Purely combinational encoder: request kind plus register/immediate fields
// to a 32-bit MIPS instruction word.
//   kind        in  3   request kind code (kind_e)
//   rs, rt, rd  in  5   register fields (rd unused by I-format kinds)
//   imm         in  16  immediate / branch offset (unused by R-format kinds)
//   word        out 32  encoded instruction
module instr_encode_comb
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word
);

  // Select the format and opcode/funct from the kind code
  always_comb begin
    word = '0;
    case (kind_e'(kind))
      KIND_ADD: word = r_word(rs, rt, rd, FN_ADD);
      KIND_SUB: word = r_word(rs, rt, rd, FN_SUB);
      KIND_AND: word = r_word(rs, rt, rd, FN_AND);
      KIND_OR:  word = r_word(rs, rt, rd, FN_OR);
      KIND_SLT: word = r_word(rs, rt, rd, FN_SLT);
      KIND_LW:  word = i_word(OP_LW,  rs, rt, imm);
      KIND_SW:  word = i_word(OP_SW,  rs, rt, imm);
      KIND_BEQ: word = i_word(OP_BEQ, rs, rt, imm);
      default:  word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
// Instruction-memory loader. After start, accepts num_instr requests (one
// per cycle at most), encodes each into a MIPS word and writes it to
// consecutive word addresses beginning at base_addr (wrapping).
//   clk, rst_n       clock / asynchronous active-low reset
//   start            load request, sampled only when idle
//   base_addr        first word address, sampled with start
//   num_instr        number of instructions, sampled with start
//   busy             high whenever not idle
//   done             one-cycle pulse when a load completes
//   req              request channel (slave side)
//   im_we            instruction-memory write strobe
//   im_addr          write word address
//   im_wdata         encoded instruction
//   wr_count         words written in the current/last load
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_instr,
  output logic              busy,
  output logic              done,
  instr_encoder_if.slave    req,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [CNT_W-1:0]  wr_count
);

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  remaining;
  logic              ready_q;
  logic [31:0]       enc_word;

  instr_encode_comb u_encode (
    .kind (req.req_kind),
    .rs   (req.req_rs),
    .rt   (req.req_rt),
    .rd   (req.req_rd),
    .imm  (req.req_imm),
    .word (enc_word)
  );

  assign req.req_ready = ready_q;

  // Loader FSM; every output is a register updated alongside the state, and
  // an accepted request lands in the write register so it appears one cycle
  // later. The last write therefore happens while in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ready_q   <= 1'b0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
      wr_count  <= '0;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            wr_count <= '0;
            busy     <= 1'b1;
            if (num_instr != '0) begin
              ptr       <= base_addr;
              remaining <= num_instr;
              ready_q   <= 1'b1;
              state     <= ST_RUN;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (req.req_valid) begin
            im_we     <= 1'b1;
            im_addr   <= ptr;
            im_wdata  <= enc_word;
            ptr       <= ptr + ADDR_W'(1);
            wr_count  <= wr_count + CNT_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              ready_q <= 1'b0;
              state   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
